axil_apb_bridge_mc: RTL and testbench

Parametrised successor to the AXI-Lite-to-APB periphery bridge. It accepts one AXI-Lite transaction at a time and decodes the address across SLV_QTY uniformly-strided APB slave windows. It drives a per-slave PSEL on a shared APB bus and returns AXI responses. Unlike the single-target bridge, it adds read/write fairness arbitration, DECERR for unmapped addresses, and a programmable PREADY timeout that converts a hung slave into SLVERR. It sits between the core's AXI-Lite crossbar port and the timer/RTC periphery slaves.

---
 rtl/axil_apb_pkg.sv | 49 ++++
 rtl/axil_apb_bridge_mc_if.sv | 51 +++++
 rtl/axil_apb_decoder.sv | 34 +++
 rtl/axil_apb_bridge_mc.sv | 159 +++++++++++++++
 tb/tb_axil_apb_bridge_mc.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/axil_apb_pkg.sv
// Shared definitions for the AXI-Lite to multi-slave APB bridge:
// response codes, FSM state encoding, timeout counter sizing and the
// address-window decode function used by the decoder.
package axil_apb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  // Width of the slave index carried by the decode result (up to 256 slaves).
  localparam int IDX_W = 8;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Counter width able to hold TIMEOUT_CYC; never narrower than one bit so a
  // disabled timeout (0) still yields a legal vector.
  function automatic int tmo_cnt_w(input int timeout_cyc);
    return (timeout_cyc < 1) ? 1 : $clog2(timeout_cyc + 1);
  endfunction

  // Uniformly strided windows: slave i covers [base + i*size, base + (i+1)*size).
  // Arithmetic is done in 64 bits so the top of a window ending at 2**AW
  // does not wrap.
  function automatic dec_t decode(input logic [63:0] addr,
                                  input logic [63:0] base,
                                  input int          size_log2,
                                  input int          qty);
    logic [63:0] off;
    dec_t        d;
    d   = '0;
    off = addr - base;
    if ((addr >= base) && ((off >> size_log2) < 64'(qty))) begin
      d.hit = 1'b1;
      d.idx = IDX_W'(off >> size_log2);
    end
    return d;
  endfunction

endpackage

// File: rtl/axil_apb_bridge_mc_if.sv
// Bus bundle between the AXI-Lite master, the bridge and the APB slaves.
//   slave  modport : bridge view (AXI-Lite slave side, APB master side)
//   master modport : environment view (drives AXI requests and APB replies)
// APB slave i returns read data on prdata[i*DW +: DW].
interface axil_apb_bridge_mc_if #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SLV_QTY = 2
) ();

  logic                  aw_valid, aw_ready;
  logic [AW-1:0]         aw_addr;
  logic [2:0]            aw_prot;
  logic                  w_valid, w_ready;
  logic [DW-1:0]         w_data;
  logic [DW/8-1:0]       w_strb;
  logic                  b_valid, b_ready;
  logic [1:0]            b_resp;
  logic                  ar_valid, ar_ready;
  logic [AW-1:0]         ar_addr;
  logic [2:0]            ar_prot;
  logic                  r_valid, r_ready;
  logic [DW-1:0]         r_data;
  logic [1:0]            r_resp;

  logic [AW-1:0]         paddr;
  logic [2:0]            pprot;
  logic [SLV_QTY-1:0]    psel;
  logic                  penable;
  logic                  pwrite;
  logic [DW-1:0]         pwdata;
  logic [DW/8-1:0]       pstrb;
  logic [SLV_QTY-1:0]    pready;
  logic [SLV_QTY*DW-1:0] prdata;
  logic [SLV_QTY-1:0]    pslverr;

  modport slave (
    input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready, pready, prdata, pslverr,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp,
           paddr, pprot, psel, penable, pwrite, pwdata, pstrb
  );

  modport master (
    output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready, pready, prdata, pslverr,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp,
           paddr, pprot, psel, penable, pwrite, pwdata, pstrb
  );

endinterface

// File: rtl/axil_apb_decoder.sv
// Combinational address decoder: maps an address onto one of SLV_QTY
// equally sized APB windows starting at PERIPH_BA.
//   i_addr : request address
//   o_hit  : address falls inside one of the windows
//   o_sel  : one-hot slave select (all zero on a miss)
module axil_apb_decoder
  import axil_apb_pkg::*;
#(
  parameter int            AW        = 32,
  parameter int            SLV_QTY   = 2,
  parameter logic [AW-1:0] PERIPH_BA = '0,
  parameter logic [AW-1:0] SLV_SIZE  = AW'(32'h0000_1000)
) (
  input  logic [AW-1:0]      i_addr,
  output logic               o_hit,
  output logic [SLV_QTY-1:0] o_sel
);

  localparam int SIZE_LOG2 = $clog2(SLV_SIZE);

  dec_t w_dec;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_dec = decode(64'(i_addr), 64'(PERIPH_BA), SIZE_LOG2, SLV_QTY);
    o_hit = w_dec.hit;
    o_sel = '0;
    for (int i = 0; i < SLV_QTY; i++) begin
      o_sel[i] = w_dec.hit && (w_dec.idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/axil_apb_bridge_mc.sv
// AXI-Lite to multi-slave APB bridge. One transaction in flight; write and
// read requests that arrive together are granted alternately. Unmapped
// addresses return DECERR without an APB cycle, and a slave that holds
// PREADY low for TIMEOUT_CYC access cycles is abandoned with SLVERR.
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   bus   : AXI-Lite slave + APB master signals (slave modport)
module axil_apb_bridge_mc
  import axil_apb_pkg::*;
#(
  parameter int                     AXI_LITE_AW = 32,
  parameter int                     AXI_LITE_DW = 32,
  parameter int                     SLV_QTY     = 2,
  parameter logic [AXI_LITE_AW-1:0] PERIPH_BA   = '0,
  parameter logic [AXI_LITE_AW-1:0] SLV_SIZE    = AXI_LITE_AW'(32'h0000_1000),
  parameter int                     TIMEOUT_CYC = 256
) (
  input logic              clk_i,
  input logic              rst_i,
  axil_apb_bridge_mc_if.slave bus
);

  localparam int AW    = AXI_LITE_AW;
  localparam int DW    = AXI_LITE_DW;
  localparam int SW    = DW / 8;
  localparam int CNT_W = tmo_cnt_w(TIMEOUT_CYC);

  state_t             r_state, w_state_nxt;
  logic               r_last_wr;      // 1: last grant was a write
  logic               r_write;
  logic [AW-1:0]      r_addr;
  logic [2:0]         r_prot;
  logic [DW-1:0]      r_wdata;
  logic [SW-1:0]      r_strb;
  logic [SLV_QTY-1:0] r_sel;
  logic [1:0]         r_xresp;
  logic [DW-1:0]      r_xdata;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_idle, w_grant_wr, w_grant_rd, w_accept;
  logic [AW-1:0]      w_req_addr;
  logic               w_hit;
  logic [SLV_QTY-1:0] w_dec_sel;
  logic               w_pready, w_pslverr, w_timeout;
  logic [DW-1:0]      w_prdata;

  // Fairness: with both pending, grant the opposite of the last grant.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_grant_wr = w_idle & bus.aw_valid & bus.w_valid &
                      (~bus.ar_valid | ~r_last_wr);
  assign w_grant_rd = w_idle & bus.ar_valid &
                      (~(bus.aw_valid & bus.w_valid) | r_last_wr);
  assign w_accept   = w_grant_wr | w_grant_rd;
  assign w_req_addr = w_grant_wr ? bus.aw_addr : bus.ar_addr;

  axil_apb_decoder #(
    .AW(AW), .SLV_QTY(SLV_QTY), .PERIPH_BA(PERIPH_BA), .SLV_SIZE(SLV_SIZE)
  ) u_dec (
    .i_addr(w_req_addr),
    .o_hit (w_hit),
    .o_sel (w_dec_sel)
  );

  // Pick the selected slave's reply out of the shared APB return bus.
  always_comb begin
    w_prdata  = '0;
    w_pready  = 1'b0;
    w_pslverr = 1'b0;
    for (int i = 0; i < SLV_QTY; i++) begin
      if (r_sel[i]) begin
        w_prdata  = w_prdata | bus.prdata[i*DW +: DW];
        w_pready  = w_pready | bus.pready[i];
        w_pslverr = w_pslverr | bus.pslverr[i];
      end
    end
  end

  // r_cnt counts completed ACCESS cycles, so the last allowed cycle sees
  // TIMEOUT_CYC-1.
  assign w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = w_hit ? ST_SETUP : ST_RESP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (w_pready || w_timeout) w_state_nxt = ST_RESP;
      ST_RESP:   if (r_write ? bus.b_ready : bus.r_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_wr <= 1'b1;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_prot    <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_sel     <= '0;
      r_xresp   <= RESP_OKAY;
      r_xdata   <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_write   <= w_grant_wr;
          r_last_wr <= w_grant_wr;
          r_addr    <= {w_req_addr[AW-1:2], 2'b00};
          r_prot    <= w_grant_wr ? bus.aw_prot : bus.ar_prot;
          r_wdata   <= w_grant_wr ? bus.w_data : '0;
          r_strb    <= w_grant_wr ? bus.w_strb : '0;
          r_sel     <= w_dec_sel;
          r_cnt     <= '0;
          r_xresp   <= w_hit ? RESP_OKAY : RESP_DECERR;
          r_xdata   <= '0;
        end
        ST_ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_pready) begin
            r_xresp <= w_pslverr ? RESP_SLVERR : RESP_OKAY;
            r_xdata <= r_write ? '0 : w_prdata;
          end else if (w_timeout) begin
            r_xresp <= RESP_SLVERR;
            r_xdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from the state register, so an asynchronous
  // reset drops psel/penable/valid without waiting for a clock.
  assign bus.aw_ready = w_grant_wr;
  assign bus.w_ready  = w_grant_wr;
  assign bus.ar_ready = w_grant_rd;
  assign bus.b_valid  = (r_state == ST_RESP) & r_write;
  assign bus.r_valid  = (r_state == ST_RESP) & ~r_write;
  assign bus.b_resp   = r_xresp;
  assign bus.r_resp   = r_xresp;
  assign bus.r_data   = r_xdata;
  assign bus.psel     = ((r_state == ST_SETUP) || (r_state == ST_ACCESS)) ? r_sel : '0;
  assign bus.penable  = (r_state == ST_ACCESS);
  assign bus.paddr    = r_addr;
  assign bus.pprot    = r_prot;
  assign bus.pwrite   = r_write;
  assign bus.pwdata   = r_wdata;
  assign bus.pstrb    = r_strb;

endmodule

// File: tb/tb_axil_apb_bridge_mc.sv
// Testbench for axil_apb_bridge_mc: table of directed transactions plus
// hand-written sequences for reset mid-access and read/write arbitration.
module tb_axil_apb_bridge_mc;
  import axil_apb_pkg::*;

  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam int          NS  = 2;
  localparam int          TMO = 8;
  localparam logic [31:0] BA  = 32'h1000_0000;
  localparam logic [31:0] SZ  = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axil_apb_bridge_mc_if #(.AW(AW), .DW(DW), .SLV_QTY(NS)) bus ();

  axil_apb_bridge_mc #(
    .AXI_LITE_AW(AW), .AXI_LITE_DW(DW), .SLV_QTY(NS),
    .PERIPH_BA(BA), .SLV_SIZE(SZ), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          wait_n;
    logic        hang;
    logic        perr;
    logic [31:0] prd;
    logic [1:0]  exp_sel;
    int          exp_acc;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_master();
    bus.aw_valid = 1'b0; bus.aw_addr = '0; bus.aw_prot = '0;
    bus.w_valid  = 1'b0; bus.w_data  = '0; bus.w_strb  = '0;
    bus.ar_valid = 1'b0; bus.ar_addr = '0; bus.ar_prot = '0;
    bus.b_ready  = 1'b0; bus.r_ready = 1'b0;
  endtask

  // Unselected slaves answer ready/error with all-ones data, so a broken
  // slave mux shows up as wrong data or early completion.
  task automatic drive_slaves(input logic [1:0] sel, input logic rdy, input logic perr,
                              input logic [31:0] prd);
    for (int i = 0; i < NS; i++) begin
      if (sel[i]) begin
        bus.pready[i] = rdy; bus.pslverr[i] = perr; bus.prdata[i*DW +: DW] = prd;
      end else begin
        bus.pready[i] = 1'b1; bus.pslverr[i] = 1'b1; bus.prdata[i*DW +: DW] = '1;
      end
    end
  endtask

  // Present a request at a negedge; acceptance happens on the next posedge.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] prot,
                       input logic [31:0] wdata, input logic [3:0] strb);
    @(negedge clk);
    if (wr) begin
      bus.aw_valid = 1'b1; bus.aw_addr = addr; bus.aw_prot = prot;
      bus.w_valid  = 1'b1; bus.w_data  = wdata; bus.w_strb = strb;
    end else begin
      bus.ar_valid = 1'b1; bus.ar_addr = addr; bus.ar_prot = prot;
    end
    #1;
    check(wr ? "aw_ready" : "ar_ready", wr ? {bus.aw_ready, bus.w_ready} : {1'b0, bus.ar_ready},
          wr ? 2'b11 : 2'b01);
  endtask

  // Called at the SETUP negedge; returns at the first negedge after ACCESS.
  task automatic serve_access(input logic [1:0] sel, input logic [31:0] exp_paddr,
                              input int wait_n, input logic hang, input logic perr,
                              input logic [31:0] prd, output int acc);
    logic bad;
    bad = 1'b0;
    acc = 0;
    drive_slaves(sel, 1'b0, 1'b0, '0);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!(bus.penable && bus.psel != '0)) break;
      if (bus.psel !== sel || bus.paddr !== exp_paddr) bad = 1'b1;
      drive_slaves(sel, !hang && (acc == wait_n), perr, prd);
      acc++;
    end
    drive_slaves(sel, 1'b0, 1'b0, '0);
    check("access_stable", bad, 1'b0);
  endtask

  // Called at the first RESP negedge: check response, hold a cycle, then accept.
  task automatic finish_resp(input logic wr, input logic [1:0] exp_resp,
                             input logic [31:0] exp_rdata);
    check("resp_valid", {bus.b_valid, bus.r_valid}, wr ? 2'b10 : 2'b01);
    check("resp_code", wr ? bus.b_resp : bus.r_resp, exp_resp);
    if (!wr) check("r_data", bus.r_data, exp_rdata);
    @(negedge clk);
    check("resp_hold", {bus.b_valid, bus.r_valid, wr ? bus.b_resp : bus.r_resp},
          {wr, !wr, exp_resp});
    if (wr) bus.b_ready = 1'b1; else bus.r_ready = 1'b1;
    @(negedge clk);
    bus.b_ready = 1'b0; bus.r_ready = 1'b0;
    check("resp_drop", {bus.b_valid, bus.r_valid}, 2'b00);
  endtask

  task automatic run_vec(input vec_t v);
    int acc;
    issue(v.wr, v.addr, v.prot, v.wdata, v.strb);
    @(negedge clk);
    idle_master();
    check("setup_psel", bus.psel, v.exp_sel);
    if (v.exp_sel != '0) begin
      check("setup_penable", bus.penable, 1'b0);
      check("setup_paddr", bus.paddr, {v.addr[31:2], 2'b00});
      check("setup_pwrite", bus.pwrite, v.wr);
      check("setup_pprot", bus.pprot, v.prot);
      check("setup_pstrb", bus.pstrb, v.wr ? v.strb : 4'h0);
      if (v.wr) check("setup_pwdata", bus.pwdata, v.wdata);
      serve_access(v.exp_sel, {v.addr[31:2], 2'b00}, v.wait_n, v.hang, v.perr, v.prd, acc);
      check("access_cycles", 64'(acc), 64'(v.exp_acc));
    end
    finish_resp(v.wr, v.exp_resp, v.exp_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic bad;
    logic exp_wr;
    logic perr;

    //            wr    addr          prot    wdata         strb  wt hang perr prd           sel    acc resp   rdata
    vecs[0] = '{1'b1, 32'h1000_0004, 3'b000, 32'hA5A5_5A5A, 4'hF, 0, 1'b0, 1'b0, 32'h0,        2'b01, 1, 2'b00, 32'h0};
    vecs[1] = '{1'b0, 32'h1000_1008, 3'b010, 32'h0,         4'h0, 3, 1'b0, 1'b0, 32'h1234_5678, 2'b10, 4, 2'b00, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h1000_2000, 3'b000, 32'h0,         4'h0, 0, 1'b0, 1'b0, 32'h0,        2'b00, 0, 2'b11, 32'h0};
    vecs[3] = '{1'b1, 32'h1000_0010, 3'b001, 32'h0BAD_0001, 4'hF, 0, 1'b1, 1'b0, 32'h0,        2'b01, 8, 2'b10, 32'h0};
    vecs[4] = '{1'b1, 32'h1000_1000, 3'b101, 32'h0000_0001, 4'h3, 1, 1'b0, 1'b0, 32'h0,        2'b10, 2, 2'b00, 32'h0};
    vecs[5] = '{1'b0, 32'h1000_0FFC, 3'b000, 32'h0,         4'h0, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'b01, 1, 2'b10, 32'hDEAD_BEEF};
    vecs[6] = '{1'b1, 32'h0FFF_FFFC, 3'b000, 32'h1111_2222, 4'hF, 0, 1'b0, 1'b0, 32'h0,        2'b00, 0, 2'b11, 32'h0};
    vecs[7] = '{1'b0, 32'h1000_1FFF, 3'b110, 32'h0,         4'h0, 0, 1'b0, 1'b0, 32'h0BAD_F00D, 2'b10, 1, 2'b00, 32'h0BAD_F00D};

    idle_master();
    drive_slaves(2'b00, 1'b0, 1'b0, '0);

    // Reset state.
    #12;
    check("rst_psel_penable", {bus.psel, bus.penable}, 3'b000);
    check("rst_valid", {bus.b_valid, bus.r_valid}, 2'b00);
    check("rst_ready", {bus.aw_ready, bus.w_ready, bus.ar_ready}, 3'b000);
    check("rst_apb_regs", {bus.paddr, bus.pwrite, bus.pstrb}, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset while a write sits in ACCESS with a hung slave.
    issue(1'b1, 32'h1000_0000, 3'b000, 32'h7777_7777, 4'hF);
    @(negedge clk);
    idle_master();
    drive_slaves(2'b01, 1'b0, 1'b0, '0);
    @(negedge clk);
    check("pre_rst_access", {bus.psel, bus.penable}, 3'b011);
    #2 rst = 1'b1;
    #1;
    check("rst_async_apb", {bus.psel, bus.penable}, 3'b000);
    check("rst_async_bvalid", bus.b_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.b_valid || bus.r_valid || bus.psel != '0) bad = 1'b1;
    end
    check("no_resp_after_rst", bad, 1'b0);

    // Simultaneous requests: grants alternate starting with read after reset.
    for (int k = 0; k < 4; k++) begin
      exp_wr = (k % 2 == 1);
      perr   = (k == 2);
      @(negedge clk);
      bus.aw_valid = 1'b1; bus.aw_addr = 32'h1000_0000; bus.aw_prot = 3'b000;
      bus.w_valid  = 1'b1; bus.w_data  = 32'(k);        bus.w_strb  = 4'hF;
      bus.ar_valid = 1'b1; bus.ar_addr = 32'h1000_1004; bus.ar_prot = 3'b000;
      #1;
      check("arb_grant", {bus.aw_ready, bus.w_ready, bus.ar_ready}, {exp_wr, exp_wr, !exp_wr});
      @(negedge clk);
      idle_master();
      check("arb_pwrite", bus.pwrite, exp_wr);
      check("arb_psel", bus.psel, exp_wr ? 2'b01 : 2'b10);
      serve_access(exp_wr ? 2'b01 : 2'b10, exp_wr ? 32'h1000_0000 : 32'h1000_1004,
                   0, 1'b0, perr, 32'h5500_0000 | 32'(k), acc);
      check("arb_access_cycles", 64'(acc), 64'd1);
      finish_resp(exp_wr, perr ? RESP_SLVERR : RESP_OKAY, 32'h5500_0000 | 32'(k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
